// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, instruction opcodes,
// the ALU opcode encoding also used by the datapath ALU, and width defaults.
package ctrl_pkg;

  localparam int PC_W_DEF = 8;
  localparam int IW_DEF   = 9;
  localparam int OPW_DEF  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_XOR  = 3'b011,
    OP_BZ   = 3'b100,
    OP_BN   = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } instr_op_e;

  typedef enum logic {
    BR_Z,
    BR_N
  } br_kind_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

endpackage

// File: rtl/seq_decode.sv
// Purely combinational instruction decoder: splits the word into fields and
// classifies it as ALU, branch (with kind) or halt; anything else is a NOP.
module seq_decode
  import ctrl_pkg::*;
#(
  parameter int IW  = IW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic [IW-1:0]  instr_i,
  output logic [OPW-1:0] alu_op_o,
  output logic [2:0]     rd_o,
  output logic [2:0]     rs_o,
  output logic [5:0]     offset_o,
  output logic           is_alu_o,
  output logic           is_branch_o,
  output br_kind_e       br_kind_o,
  output logic           is_halt_o
);

  instr_op_e opcode;

  assign opcode   = instr_op_e'(instr_i[8:6]);
  assign rd_o     = instr_i[5:3];
  assign rs_o     = instr_i[2:0];
  assign offset_o = instr_i[5:0];

  always_comb begin
    alu_op_o    = OPW'(ALU_ADD);
    is_alu_o    = 1'b0;
    is_branch_o = 1'b0;
    br_kind_o   = BR_Z;
    is_halt_o   = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_op_o = OPW'(ALU_ADD);
        is_alu_o = 1'b1;
      end
      OP_SHR: begin
        alu_op_o = OPW'(ALU_SHR);
        is_alu_o = 1'b1;
      end
      OP_SHL: begin
        alu_op_o = OPW'(ALU_SHL);
        is_alu_o = 1'b1;
      end
      OP_XOR: begin
        alu_op_o = OPW'(ALU_XOR);
        is_alu_o = 1'b1;
      end
      OP_BZ: begin
        is_branch_o = 1'b1;
        br_kind_o   = BR_Z;
      end
      OP_BN: begin
        is_branch_o = 1'b1;
        br_kind_o   = BR_N;
      end
      OP_HALT: is_halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller that fetches instructions, drives the ALU/register
// file for arithmetic ops, and resolves flag-based branches and halt.
module alu_sequencer
  import ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IW   = IW_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [IW-1:0]   imem_data,
  output logic [OPW-1:0]  alu_op,
  output logic [2:0]      rf_ra,
  output logic [2:0]      rf_rb,
  output logic [2:0]      rf_wa,
  output logic            rf_we,
  input  logic            alu_zero,
  input  logic            alu_sign,
  output logic            busy,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_s_q, flag_s_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [2:0]      ra_q, ra_d;
  logic [2:0]      rb_q, rb_d;
  logic [2:0]      wa_q, wa_d;
  logic            is_alu_q, is_alu_d;
  logic            is_branch_q, is_branch_d;
  logic            is_halt_q, is_halt_d;
  br_kind_e        br_kind_q, br_kind_d;
  logic [5:0]      offset_q, offset_d;

  logic [OPW-1:0]  dec_alu_op;
  logic [2:0]      dec_rd;
  logic [2:0]      dec_rs;
  logic [5:0]      dec_offset;
  logic            dec_is_alu;
  logic            dec_is_branch;
  br_kind_e        dec_br_kind;
  logic            dec_is_halt;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] offset_ext;
  logic            br_taken;

  seq_decode #(
    .IW (IW),
    .OPW(OPW)
  ) u_decode (
    .instr_i    (imem_data),
    .alu_op_o   (dec_alu_op),
    .rd_o       (dec_rd),
    .rs_o       (dec_rs),
    .offset_o   (dec_offset),
    .is_alu_o   (dec_is_alu),
    .is_branch_o(dec_is_branch),
    .br_kind_o  (dec_br_kind),
    .is_halt_o  (dec_is_halt)
  );

  // Decoding the fetched word on the fetch edge lets the ALU/RF outputs be
  // registered and stable from the first DECODE cycle onward.
  assign pc_inc     = pc_q + PC_W'(1);
  assign offset_ext = {{(PC_W-6){offset_q[5]}}, offset_q};
  assign br_taken   = (br_kind_q == BR_Z) ? flag_z_q : flag_s_q;

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign rf_we     = (state_q == S_WB);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign alu_op    = alu_op_q;
  assign rf_ra     = ra_q;
  assign rf_rb     = rb_q;
  assign rf_wa     = wa_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flag_z_d    = flag_z_q;
    flag_s_d    = flag_s_q;
    alu_op_d    = alu_op_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    wa_d        = wa_q;
    is_alu_d    = is_alu_q;
    is_branch_d = is_branch_q;
    is_halt_d   = is_halt_q;
    br_kind_d   = br_kind_q;
    offset_d    = offset_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          state_d     = S_DECODE;
          is_alu_d    = dec_is_alu;
          is_branch_d = dec_is_branch;
          is_halt_d   = dec_is_halt;
          br_kind_d   = dec_br_kind;
          offset_d    = dec_offset;
          if (dec_is_alu) begin
            alu_op_d = dec_alu_op;
            ra_d     = dec_rd;
            rb_d     = dec_rs;
            wa_d     = dec_rd;
          end
        end
      end
      S_DECODE: begin
        if (is_alu_q) begin
          state_d = S_EXEC;
        end else if (is_branch_q) begin
          state_d = S_FETCH;
          pc_d    = br_taken ? (pc_inc + offset_ext) : pc_inc;
        end else if (is_halt_q) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      S_EXEC: begin
        state_d  = S_WB;
        flag_z_d = alu_zero;
        flag_s_d = alu_sign;
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      S_HALT: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          flag_z_d = 1'b0;
          flag_s_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      flag_z_q    <= 1'b0;
      flag_s_q    <= 1'b0;
      alu_op_q    <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      wa_q        <= '0;
      is_alu_q    <= 1'b0;
      is_branch_q <= 1'b0;
      is_halt_q   <= 1'b0;
      br_kind_q   <= BR_Z;
      offset_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flag_z_q    <= flag_z_d;
      flag_s_q    <= flag_s_d;
      alu_op_q    <= alu_op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      wa_q        <= wa_d;
      is_alu_q    <= is_alu_d;
      is_branch_q <= is_branch_d;
      is_halt_q   <= is_halt_d;
      br_kind_q   <= br_kind_d;
      offset_q    <= offset_d;
    end
  end

endmodule
